// File: rtl/ysyx_23060111_lsu_sram_pkg.sv
// Shared types and constants for the LSU-side SRAM responder.
package ysyx_23060111_lsu_sram_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [XLEN-1:0] BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ysyx_23060111_sram_array.sv
// Word-organised storage: combinational read, byte-masked synchronous write, no reset.
module ysyx_23060111_sram_array
  import ysyx_23060111_lsu_sram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [MASK_W-1:0]     wmask,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];

  assign rdata = mem[addr];

  // Byte-lane write; lanes with a clear mask bit keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < MASK_W; i++) begin
        if (wmask[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_23060111_lsu_sram.sv
// Memory-side responder for the LSU port: one request at a time, serviced from
// an internal word array after LATENCY busy cycles, answered over valid/ready.
module ysyx_23060111_lsu_sram
  import ysyx_23060111_lsu_sram_pkg::*;
#(
  parameter int unsigned     DEPTH_LOG2 = 12,
  parameter logic [XLEN-1:0] BASE       = ysyx_23060111_lsu_sram_pkg::BASE,
  parameter int unsigned     LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [XLEN-1:0]       off;
  logic                  err;
  logic                  accept;
  logic                  mem_we;
  logic [XLEN-1:0]       mem_rdata;
  logic                  unused_bits;

  // Address check: word-aligned and inside the window starting at BASE.
  assign off         = req_addr - BASE;
  assign err         = (req_addr[1:0] != 2'b00) || (off[XLEN-1:DEPTH_LOG2+2] != '0);
  assign unused_bits = ^off[1:0];

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign mem_we    = accept && req_wen && !err;
  assign rsp_valid = (state == RESP);

  ysyx_23060111_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (off[DEPTH_LOG2+1:2]),
    .wdata(req_wdata),
    .wmask(req_wmask),
    .rdata(mem_rdata)
  );

  // Next-state and latency-counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_n = RESP;
          end else begin
            state_n = BUSY;
            cnt_n   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Response payload: captured at the accept edge, cleared on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (err || req_wen) ? '0 : mem_rdata;
      rsp_err   <= err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060111_lsu_sram.sv
// Directed bench for the LSU SRAM responder: a LATENCY=2 instance (a) and a
// LATENCY=0 instance (b) share request fields and reset.
module tb_ysyx_23060111_lsu_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;
  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  int checks   = 0;
  int failures = 0;

  logic        sel;
  logic        v_sel, rdy_sel, err_sel;
  logic [31:0] rd_sel;
  assign v_sel   = sel ? rsp_valid_b : rsp_valid_a;
  assign rdy_sel = sel ? req_ready_b : req_ready_a;
  assign err_sel = sel ? rsp_err_b   : rsp_err_a;
  assign rd_sel  = sel ? rsp_rdata_b : rsp_rdata_a;

  ysyx_23060111_lsu_sram #(
    .DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  ysyx_23060111_lsu_sram #(
    .DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One request on the selected instance; caller sits 1 time unit after a posedge
  // with rsp_ready high. lat = edges from accept until the edge that sees rsp_valid.
  task automatic txn(input logic s, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     output logic [31:0] rd, output logic er, output int lat);
    sel       = s;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    #1;
    chk("req_ready before accept", {31'd0, rdy_sel}, 32'd1);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    lat = 1;
    while (!v_sel && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rd_sel;
    er = err_sel;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          accepts;
    logic        seen;
    int          w;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vecs[7]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0101_0101, 4'hF, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h8000_3FFC, 32'h0202_0202, 4'hF, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'h8000_4000, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b1};
    vecs[12] = '{1'b1, 32'h8000_0011, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0101_0101, 1'b0};
    vecs[14] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'h0202_0202, 1'b0};
    vecs[15] = '{1'b1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};

    sel = 1'b0;
    rst = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
    req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata_a, 32'd0);
    chk("reset rsp_err",   {31'd0, rsp_err_a}, 32'd0);
    chk("reset req_ready", {31'd0, req_ready_a}, 32'd0);
    chk("reset req_ready b", {31'd0, req_ready_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_ready after reset", {31'd0, req_ready_a}, 32'd1);
    @(posedge clk); #1;

    // Table-driven vectors on the LATENCY=2 instance
    for (int i = 0; i < 16; i++) begin
      txn(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
    end
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("misaligned write kept neighbour", rd, 32'hDEAD_BEEF);

    // Backpressure: response held 5 cycles, stray write request ignored
    sel = 1'b0;
    rsp_ready_a = 1'b0;
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    w = 0;
    while (!rsp_valid_a && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      req_wen = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'h7777_7777; req_wmask = 4'hF;
      req_valid_a = (k % 2 == 0);
      #1;
      chk($sformatf("bp%0d rsp_valid", k), {31'd0, rsp_valid_a}, 32'd1);
      chk($sformatf("bp%0d rdata", k), rsp_rdata_a, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d err", k), {31'd0, rsp_err_a}, 32'd0);
      chk($sformatf("bp%0d req_ready", k), {31'd0, req_ready_a}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    chk("bp release rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("bp release rdata", rsp_rdata_a, 32'd0);
    txn(1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("bp stray write ignored", rd, 32'h0BAD_F00D);

    // LATENCY=0 instance
    txn(1'b1, 1'b1, 32'h8000_0100, 32'h1357_9BDF, 4'hF, rd, er, lat);
    chk("lat0 write latency", 32'(lat), 32'd1);
    chk("lat0 write err", {31'd0, er}, 32'd0);
    txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0, rd, er, lat);
    chk("lat0 read latency", 32'(lat), 32'd1);
    chk("lat0 read rdata", rd, 32'h1357_9BDF);

    // LATENCY=0 back-to-back: one accept every two cycles
    req_wen = 1'b0; req_addr = 32'h8000_0100; req_valid_b = 1'b1;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready_b) accepts++;
      else chk($sformatf("b2b%0d rdata", k), rsp_rdata_b, 32'h1357_9BDF);
    end
    req_valid_b = 1'b0;
    chk("b2b accept count", 32'(accepts), 32'd5);
    @(posedge clk); #1;

    // Reset while BUSY: response dropped, committed write kept
    sel = 1'b0;
    req_wen = 1'b1; req_addr = 32'h8000_0030; req_wdata = 32'h5A5A_5A5A; req_wmask = 4'hF;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst req_ready a", {31'd0, req_ready_a}, 32'd0);
    chk("rst req_ready b", {31'd0, req_ready_b}, 32'd0);
    seen = rsp_valid_a;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= rsp_valid_a;
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= rsp_valid_a;
    end
    chk("rst mid-op rsp_valid never", {31'd0, seen}, 32'd0);
    chk("rst mid-op idle after", {31'd0, req_ready_a}, 32'd1);
    txn(1'b0, 1'b0, 32'h8000_0030, 32'h0, 4'h0, rd, er, lat);
    chk("rst mid-op write kept", rd, 32'h5A5A_5A5A);

    // Reset coincident with a valid write: nothing accepted
    rst = 1'b1;
    req_wen = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'h6666_6666; req_wmask = 4'hF;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    rst = 1'b0;
    chk("rst coincident no rsp", {31'd0, rsp_valid_a}, 32'd0);
    txn(1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, lat);
    chk("rst coincident no write", rd, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
